// File: rtl/apb_rr_arbiter_pkg.sv
// Shared types and constants for the APB round-robin arbiter.
// FSM encoding, timeout read-back value and default sizing.
package apb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [15:0] DEAD_DATA = 16'hDEAD;
  localparam int TIMEOUT_DEF = 255;
  localparam int BUS_WIDTH_DEF = 16;
  localparam int MASTER_PORTS_DEF = 4;

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of per-master APB request lanes and the single downstream APB port.
// slave: arbiter side; master: the cores plus interconnect around it.
interface apb_rr_arbiter_if #(
  parameter int BUS_WIDTH    = apb_rr_arbiter_pkg::BUS_WIDTH_DEF,
  parameter int MASTER_PORTS = apb_rr_arbiter_pkg::MASTER_PORTS_DEF
);
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PADDR;
  logic [MASTER_PORTS-1:0]           S_PWRITE;
  logic [MASTER_PORTS-1:0]           S_PSELx;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PWDATA;
  logic [MASTER_PORTS*BUS_WIDTH-1:0] S_PRDATA;
  logic [MASTER_PORTS-1:0]           S_PREADY;
  logic [BUS_WIDTH-1:0]              M_PADDR;
  logic                              M_PWRITE;
  logic [BUS_WIDTH-1:0]              M_PWDATA;
  logic                              M_PSEL;
  logic                              M_PENABLE;
  logic [BUS_WIDTH-1:0]              M_PRDATA;
  logic                              M_PREADY;

  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PWDATA,
    input  M_PRDATA, M_PREADY,
    output S_PRDATA, S_PREADY,
    output M_PADDR, M_PWRITE, M_PWDATA, M_PSEL, M_PENABLE
  );

  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PWDATA,
    output M_PRDATA, M_PREADY,
    input  S_PRDATA, S_PREADY,
    input  M_PADDR, M_PWRITE, M_PWDATA, M_PSEL, M_PENABLE
  );
endinterface

// File: rtl/apb_rr_pick.sv
// Combinational rotating-priority picker: first requester after last wins.
// Result is one-hot, or zero when nobody requests.
module apb_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick
);
  logic [IW:0]  sh;
  logic [N-1:0] rot;
  logic [N-1:0] first;

  // rotate so bit 0 is master last+1, isolate lowest set bit, rotate back
  always_comb begin
    sh    = {1'b0, last} + 1'b1;
    rot   = N'({req, req} >> sh);
    first = rot & (~rot + 1'b1);
    pick  = N'(({first, first} << sh) >> N);
  end
endmodule

// File: rtl/apb_rr_arbiter.sv
// N-to-1 APB arbiter with round-robin grant and one IDLE bubble per transfer.
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter
  import apb_rr_arbiter_pkg::*;
#(
  parameter int BUS_WIDTH    = BUS_WIDTH_DEF,
  parameter int MASTER_PORTS = MASTER_PORTS_DEF
`ifdef APB_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  apb_rr_arbiter_if.slave         bus,
  output logic [MASTER_PORTS-1:0] grant,
  output logic                    busy
`ifdef APB_ARB_TIMEOUT_EN
  , output logic                  timeout
`endif
);
  localparam int IW = $clog2(MASTER_PORTS);

  typedef logic [MASTER_PORTS-1:0][BUS_WIDTH-1:0] lanes_t;

  state_t state, state_nxt;
  logic [IW-1:0] gidx, last, pick_idx;
  logic [MASTER_PORTS-1:0] pick;
  logic done;
  lanes_t paddr_a, pwdata_a, prdata_a;
  logic [MASTER_PORTS-1:0] s_rdy;
  logic m_psel, m_pen, m_write;
  logic [BUS_WIDTH-1:0] m_addr, m_wdata;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic expire;
`endif

  apb_rr_pick #(
    .N  (MASTER_PORTS),
    .IW (IW)
  ) u_pick (
    .req  (bus.S_PSELx),
    .last (last),
    .pick (pick)
  );

  assign paddr_a  = bus.S_PADDR;
  assign pwdata_a = bus.S_PWDATA;

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < MASTER_PORTS; i++)
      if (pick[i]) pick_idx = IW'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      last  <= IW'(MASTER_PORTS - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE && |bus.S_PSELx) begin
        grant <= pick;
        gidx  <= pick_idx;
      end
      if (done) begin
        grant <= '0;
        last  <= gidx;
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      cnt <= (state == ACCESS) ? cnt + 1'b1 : '0;
      if (expire) timeout <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    m_psel    = 1'b0;
    m_pen     = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_write   = 1'b0;
    s_rdy     = '0;
    prdata_a  = '0;
`ifdef APB_ARB_TIMEOUT_EN
    expire    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (|bus.S_PSELx) state_nxt = SETUP;
      end
      SETUP: begin
        m_psel    = 1'b1;
        m_addr    = paddr_a[gidx];
        m_wdata   = pwdata_a[gidx];
        m_write   = bus.S_PWRITE[gidx];
        state_nxt = ACCESS;
      end
      ACCESS: begin
        m_psel  = 1'b1;
        m_pen   = 1'b1;
        m_addr  = paddr_a[gidx];
        m_wdata = pwdata_a[gidx];
        m_write = bus.S_PWRITE[gidx];
        if (bus.M_PREADY) begin
          done           = 1'b1;
          s_rdy[gidx]    = 1'b1;
          prdata_a[gidx] = bus.M_PRDATA;
          state_nxt      = IDLE;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          done           = 1'b1;
          expire         = 1'b1;
          m_psel         = 1'b0;
          m_pen          = 1'b0;
          s_rdy[gidx]    = 1'b1;
          prdata_a[gidx] = BUS_WIDTH'(DEAD_DATA);
          state_nxt      = IDLE;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign bus.M_PSEL    = m_psel;
  assign bus.M_PENABLE = m_pen;
  assign bus.M_PADDR   = m_addr;
  assign bus.M_PWDATA  = m_wdata;
  assign bus.M_PWRITE  = m_write;
  assign bus.S_PREADY  = s_rdy;
  assign bus.S_PRDATA  = prdata_a;
endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter against a transaction-level model.
// Define APB_ARB_TIMEOUT_EN to also exercise the ACCESS watchdog.
`timescale 1ns/1ps
module tb_apb_rr_arbiter;
  localparam int N  = 4;
  localparam int BW = 16;
  localparam int TO = 8;
  localparam int VW = 2 + 2*BW + 1 + N + N*BW + N + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] grant;
  logic busy;
`ifdef APB_ARB_TIMEOUT_EN
  logic timeout;
`endif

  int checks = 0;
  int errors = 0;

  // model: owner -1 means free; age 0 = select phase, age k = k-th enable cycle
  int m_owner = -1;
  int m_age = 0;
  int m_last = N - 1;
  bit m_to = 1'b0;
  logic [N-1:0] p_sel = '0;
  logic p_rdy = 1'b0;
  logic p_rst = 1'b0;
  logic [N-1:0] e_rdy;
  logic [VW-1:0] exp_v, obs_v;

  apb_rr_arbiter_if #(.BUS_WIDTH(BW), .MASTER_PORTS(N)) bus();

  apb_rr_arbiter #(
    .BUS_WIDTH      (BW),
    .MASTER_PORTS   (N)
`ifdef APB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (TO)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .grant (grant),
    .busy  (busy)
`ifdef APB_ARB_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_last  = N - 1;
    m_to    = 1'b0;
  endtask

  task automatic model_update();
    int i;
    if (!p_rst) return;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        i = (m_last + k) % N;
        if (p_sel[i] && m_owner < 0) begin
          m_owner = i;
          m_age = 0;
        end
      end
    end else if (m_age == 0) m_age = 1;
    else if (p_rdy) begin
      m_last = m_owner;
      m_owner = -1;
    end
`ifdef APB_ARB_TIMEOUT_EN
    else if (m_age == TO) begin
      m_last = m_owner;
      m_owner = -1;
      m_to = 1'b1;
    end
`endif
    else m_age++;
  endtask

  task automatic model_eval();
    logic e_psel, e_pen, e_wr, e_busy;
    logic [BW-1:0] e_addr, e_wd;
    logic [N-1:0] e_gnt;
    logic [N*BW-1:0] e_rd;
    e_psel = 0; e_pen = 0; e_wr = 0; e_busy = 0;
    e_addr = '0; e_wd = '0; e_gnt = '0; e_rd = '0; e_rdy = '0;
    if (m_owner >= 0) begin
      e_busy = 1'b1;
      e_gnt[m_owner] = 1'b1;
      e_psel = 1'b1;
      e_addr = bus.S_PADDR[m_owner*BW +: BW];
      e_wd = bus.S_PWDATA[m_owner*BW +: BW];
      e_wr = bus.S_PWRITE[m_owner];
      if (m_age >= 1) begin
        e_pen = 1'b1;
        if (bus.M_PREADY) begin
          e_rdy[m_owner] = 1'b1;
          e_rd[m_owner*BW +: BW] = bus.M_PRDATA;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (m_age == TO) begin
          e_psel = 1'b0;
          e_pen = 1'b0;
          e_rdy[m_owner] = 1'b1;
          e_rd[m_owner*BW +: BW] = 16'hDEAD;
        end
`endif
      end
    end
    exp_v = {e_psel, e_pen, e_addr, e_wr, e_wd, e_rdy, e_rd, e_gnt, e_busy};
    obs_v = {bus.M_PSEL, bus.M_PENABLE, bus.M_PADDR, bus.M_PWRITE,
             bus.M_PWDATA, bus.S_PREADY, bus.S_PRDATA, grant, busy};
  endtask

  task automatic tick(input logic [N-1:0] sel, input logic rdy,
                      input logic [BW-1:0] rd);
    @(negedge clk);
    model_update();
    bus.S_PSELx = sel;
    bus.M_PREADY = rdy;
    bus.M_PRDATA = rd;
    if (!reset) model_reset();
    p_sel = sel;
    p_rdy = rdy;
    p_rst = reset;
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick('0, 1'b0, '0);
    reset = 1'b1;
    p_rst = 1'b1;
  endtask

  task automatic set_lane(input int i, input logic [BW-1:0] a,
                          input logic [BW-1:0] d, input logic w);
    bus.S_PADDR[i*BW +: BW] = a;
    bus.S_PWDATA[i*BW +: BW] = d;
    bus.S_PWRITE[i] = w;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int t = 0; t < 2; t++) begin
      tick(t == 0 ? '1 : '0, 1'b1, 16'h5A5A);
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL reset_vec t=%0d got %h exp %h", t, obs_v, exp_v);
      if (obs_v !== exp_v) errors++;
      checks++;
      if ({grant, busy, bus.M_PSEL, bus.S_PREADY} !== '0) begin
        errors++;
        $display("FAIL reset_out t=%0d got g=%b b=%b sel=%b rdy=%b exp 0",
                 t, grant, busy, bus.M_PSEL, bus.S_PREADY);
      end
    end
    reset = 1'b1;
    p_rst = 1'b1;
  endtask

  task automatic test_single();
    set_lane(2, 16'h00A0, 16'h0055, 1'b1);
    for (int t = 0; t < 4; t++) begin
      tick(t < 3 ? 4'b0100 : 4'b0000, 1'b1, 16'($urandom));
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL single_vec t=%0d got %h exp %h", t, obs_v, exp_v);
      end
      if (t == 1) begin
        checks++;
        if (bus.M_PSEL !== 1'b1 || bus.M_PENABLE !== 1'b0 ||
            bus.M_PADDR !== 16'h00A0 || bus.M_PWDATA !== 16'h0055 ||
            bus.M_PWRITE !== 1'b1) begin
          errors++;
          $display("FAIL single_setup got sel=%b en=%b a=%h d=%h w=%b exp 1 0 00a0 0055 1",
                   bus.M_PSEL, bus.M_PENABLE, bus.M_PADDR, bus.M_PWDATA, bus.M_PWRITE);
        end
      end
      if (t == 2) begin
        checks++;
        if (bus.M_PENABLE !== 1'b1 || bus.S_PREADY !== 4'b0100) begin
          errors++;
          $display("FAIL single_access got en=%b rdy=%b exp 1 0100",
                   bus.M_PENABLE, bus.S_PREADY);
        end
      end
    end
  endtask

  task automatic test_fair();
    int gseq[$];
    int rcyc[$];
    int exp_o[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] prev_g;
    int gi;
    prev_g = '0;
    do_reset();
    for (int t = 0; t < 15; t++) begin
      tick('1, 1'b1, 16'($urandom));
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL fair_vec t=%0d got %h exp %h", t, obs_v, exp_v);
      end
      if (grant != '0 && grant != prev_g) begin
        gi = -1;
        for (int i = 0; i < N; i++) if (grant[i]) gi = i;
        gseq.push_back(gi);
      end
      prev_g = grant;
      if (|bus.S_PREADY) rcyc.push_back(t);
    end
    checks++;
    if (gseq.size() != 5) begin
      errors++;
      $display("FAIL fair_count got %0d grants exp 5", gseq.size());
    end
    for (int i = 0; i < gseq.size() && i < 5; i++) begin
      checks++;
      if (gseq[i] != exp_o[i]) begin
        errors++;
        $display("FAIL fair_order idx=%0d got %0d exp %0d", i, gseq[i], exp_o[i]);
      end
    end
    for (int i = 1; i < rcyc.size(); i++) begin
      checks++;
      if (rcyc[i] - rcyc[i-1] != 3) begin
        errors++;
        $display("FAIL fair_period idx=%0d got %0d exp 3", i, rcyc[i] - rcyc[i-1]);
      end
    end
  endtask

  task automatic test_wait_read();
    logic [N*BW-1:0] want;
    set_lane(1, 16'h0085, 16'($urandom), 1'b0);
    for (int t = 0; t < 9; t++) begin
      tick(t < 8 ? 4'b0010 : 4'b0000, t == 7, t == 7 ? 16'h1234 : 16'($urandom));
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL wait_vec t=%0d got %h exp %h", t, obs_v, exp_v);
      end
      want = (t == 7) ? 64'h0000_0000_1234_0000 : 64'h0;
      checks++;
      if (bus.S_PRDATA !== want) begin
        errors++;
        $display("FAIL wait_rdata t=%0d got %h exp %h", t, bus.S_PRDATA, want);
      end
    end
  endtask

  task automatic test_hold();
    logic [N-1:0] sels [9] = '{4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b1001,
                               4'b1000, 4'b1000, 4'b1000, 4'b0000};
    logic [N-1:0] want;
    do_reset();
    for (int t = 0; t < 9; t++) begin
      tick(sels[t], t == 4 || t == 7, 16'($urandom));
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL hold_vec t=%0d got %h exp %h", t, obs_v, exp_v);
      end
      if ((t >= 1 && t <= 4) || t == 6 || t == 7) begin
        want = (t <= 4) ? 4'b0001 : 4'b1000;
        checks++;
        if (grant !== want) begin
          errors++;
          $display("FAIL hold_grant t=%0d got %b exp %b", t, grant, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 3; t++) tick(4'b0010, 1'b0, 16'($urandom));
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    model_eval();
    p_rst = 1'b0;
    checks++;
    if (obs_v !== exp_v || {bus.M_PSEL, bus.M_PENABLE, bus.S_PREADY, grant, busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_async got %h exp %h", obs_v, exp_v);
    end
    tick(4'b1111, 1'b1, 16'hBEEF);
    checks++;
    if (obs_v !== exp_v || bus.S_PREADY !== '0) begin
      errors++;
      $display("FAIL rstmid_hold got %h exp %h", obs_v, exp_v);
    end
    reset = 1'b1;
    p_rst = 1'b1;
    tick(4'b1111, 1'b1, 16'($urandom));
    checks++;
    if (grant !== 4'b0001) begin
      errors++;
      $display("FAIL rstmid_first got %b exp 0001", grant);
    end
    for (int t = 0; t < 3; t++) begin
      tick('0, 1'b1, 16'($urandom));
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL rstmid_drain t=%0d got %h exp %h", t, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    r = '0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!r[i] && i != m_owner && $urandom_range(3) == 0) begin
          r[i] = 1'b1;
          set_lane(i, 16'($urandom), 16'($urandom), 1'($urandom));
        end
      end
      // occasionally the owner abandons its request mid-transfer
      if (m_owner >= 0 && $urandom_range(15) == 0) r[m_owner] = 1'b0;
      tick(r, 1'($urandom), 16'($urandom));
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL random_vec t=%0d got %h exp %h", t, obs_v, exp_v);
      end
      r = r & ~e_rdy;
    end
  endtask

`ifdef APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    for (int t = 0; t < 12; t++) begin
      tick(t < 10 ? 4'b0001 : 4'b0000, 1'b0, 16'($urandom));
      checks++;
      if (obs_v !== exp_v || timeout !== m_to) begin
        errors++;
        $display("FAIL timeout_vec t=%0d got %h to=%b exp %h to=%b",
                 t, obs_v, timeout, exp_v, m_to);
      end
      if (t == 9) begin
        checks++;
        if (bus.S_PREADY !== 4'b0001 || bus.S_PRDATA[15:0] !== 16'hDEAD ||
            bus.M_PSEL !== 1'b0) begin
          errors++;
          $display("FAIL timeout_fire got rdy=%b d=%h sel=%b exp 0001 dead 0",
                   bus.S_PREADY, bus.S_PRDATA[15:0], bus.M_PSEL);
        end
      end
      if (t == 11) begin
        checks++;
        if (timeout !== 1'b1) begin
          errors++;
          $display("FAIL timeout_flag got %b exp 1", timeout);
        end
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.S_PSELx  = '0;
    bus.S_PADDR  = {$urandom, $urandom};
    bus.S_PWDATA = {$urandom, $urandom};
    bus.S_PWRITE = 4'($urandom);
    bus.M_PREADY = 1'b0;
    bus.M_PRDATA = '0;
    test_reset();
    test_single();
    test_fair();
    test_wait_read();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
